// File: rtl/fir_stream_pkg.sv
// Shared definitions for the FIR stream driver: FSM encoding and counter width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_stream_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DELIVER = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } state_e;

  // Width of a counter that must hold the value num_samples itself.
  function automatic int cnt_w(input int num_samples);
    return $clog2(num_samples + 1);
  endfunction

  // Per-sample timer width; it counts 0 .. timeout_cycles-1.
  function automatic int timer_w(input int timeout_cycles);
    return (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous DEPTH x WIDTH sample FIFO with wrap-around pointers (extra MSB tells full from empty).
// Latency: a pushed word is visible on dout the cycle after the push; no bypass when empty.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keeps occupancy.
// Ports: clk/reset, push/din in, pop in, dout/full/empty out.
module fir_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_stream_driver.sv
// Drives the FIR one sample at a time from an ingress FIFO and forwards each result downstream.
// Latency: FIFO head -> input_Valid in 2 cycles (FETCH, ISSUE); output_Valid -> m_valid in 1 cycle.
// Backpressure: s_ready = FIFO not full; m_valid/m_data hold until m_ready, no new issue meanwhile.
// Ports: start/busy/done/timeout_err/sample_count run control; s_* sample in; FIR_* / *_Valid FIR side; m_* result out.
module fir_stream_driver
  import fir_stream_pkg::*;
#(
  parameter int INPUT_WIDTH    = 16,
  parameter int OUTPUT_WIDTH   = 38,
  parameter int NUM_SAMPLES    = 1024,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [INPUT_WIDTH-1:0]           s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [INPUT_WIDTH-1:0]           FIR_input,
  output logic                             input_Valid,
  input  logic [OUTPUT_WIDTH-1:0]          FIR_output,
  input  logic                             output_Valid,
  output logic [OUTPUT_WIDTH-1:0]          m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             timeout_err,
  output logic [$clog2(NUM_SAMPLES+1)-1:0] sample_count
);

  localparam int CNT_W   = cnt_w(NUM_SAMPLES);
  localparam int TIMER_W = timer_w(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  hold_q, hold_d;
  logic [OUTPUT_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [TIMER_W-1:0]      timer_q, timer_d, timer_inc;
  logic                    ready_en_q;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [INPUT_WIDTH-1:0]  fifo_dout;

  // s_ready stays low through reset and rises on the first cycle after it is released.
  assign s_ready   = ready_en_q && !fifo_full;
  assign fifo_push = s_valid && s_ready;

  fir_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INPUT_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cnt_inc   = cnt_q + 1'b1;
  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_dout;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (output_Valid) begin
          m_data_d  = FIR_output;
          m_valid_d = 1'b1;
          state_d   = ST_DELIVER;
        end else begin
          timer_d = timer_inc;
          // Bounds WAIT to TIMEOUT_CYCLES-1 cycles, so the error flag shows
          // TIMEOUT_CYCLES cycles after the issue pulse.
          if (timer_inc == TIMER_W'(TIMEOUT_CYCLES - 1)) state_d = ST_ERROR;
        end
      end
      ST_DELIVER: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = cnt_inc;
          state_d   = (cnt_inc == CNT_W'(NUM_SAMPLES)) ? ST_DONE : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      cnt_q      <= '0;
      timer_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      ready_en_q <= 1'b1;
    end
  end

  // hold_q drives the FIR through ISSUE and WAIT since the FIR captures it a cycle after the pulse.
  assign FIR_input    = hold_q;
  assign input_Valid  = (state_q == ST_ISSUE);
  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign busy         = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                        (state_q == ST_WAIT)  || (state_q == ST_DELIVER);
  assign done         = (state_q == ST_DONE);
  assign timeout_err  = (state_q == ST_ERROR);
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
module tb_fir_stream_driver;

  localparam int IW      = 16;
  localparam int OW      = 38;
  localparam int NS      = 4;
  localparam int CW      = $clog2(NS + 1);
  localparam int FIR_LAT = 200;

  logic          clk, reset;
  // instance A: long timeout, driven by the FIR model
  logic          start, s_valid, s_ready, input_Valid, output_Valid;
  logic [IW-1:0] s_data, FIR_input;
  logic [OW-1:0] FIR_output, m_data;
  logic          m_valid, m_ready, busy, done, timeout_err;
  logic [CW-1:0] sample_count;
  // instance B: 16-cycle timeout, FIR never answers
  logic          b_start, b_s_valid, b_s_ready, b_iv, b_m_valid, b_busy, b_done, b_to;
  logic [IW-1:0] b_s_data, b_fir_in;
  logic [OW-1:0] b_m_data;
  logic [CW-1:0] b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // bench-side state written only by the negedge monitor
  int            pulse_cnt = 0;
  bit            double_iv = 0;
  bit            prev_iv   = 0;
  bit            cap_pend  = 0;
  int            lat_cnt   = 0;
  logic [IW-1:0] fir_smp;
  int            stray_seen = 0;
  logic [IW-1:0] samp_q[$];
  logic [OW-1:0] res_q[$];
  // written only by the tasks
  int            stray_cnt = 0;

  fir_stream_driver #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NUM_SAMPLES(NS), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(512)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FIR_input(FIR_input), .input_Valid(input_Valid), .FIR_output(FIR_output), .output_Valid(output_Valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done),
    .timeout_err(timeout_err), .sample_count(sample_count)
  );

  fir_stream_driver #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NUM_SAMPLES(NS), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .FIR_input(b_fir_in), .input_Valid(b_iv), .FIR_output('0), .output_Valid(1'b0),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(1'b1), .busy(b_busy), .done(b_done),
    .timeout_err(b_to), .sample_count(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIR model and stream monitor: samples the DUT on the falling edge, drives the FIR strobe there too.
  always @(negedge clk) begin
    output_Valid = 1'b0;
    if (input_Valid) pulse_cnt++;
    if (input_Valid && prev_iv) double_iv = 1'b1;
    prev_iv = input_Valid;
    if (m_valid && m_ready) res_q.push_back(m_data);
    if (reset) begin
      cap_pend = 1'b0;
      lat_cnt  = 0;
    end else begin
      if (cap_pend) begin
        fir_smp  = FIR_input;
        samp_q.push_back(FIR_input);
        lat_cnt  = FIR_LAT;
        cap_pend = 1'b0;
      end
      if (input_Valid) cap_pend = 1'b1;
      if (lat_cnt != 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          output_Valid = 1'b1;
          FIR_output   = OW'(fir_smp) * OW'(3);
        end
      end
    end
    if (stray_cnt != stray_seen) begin
      stray_seen   = stray_cnt;
      output_Valid = 1'b1;
      FIR_output   = OW'(38'h1234);
    end
  end

  // All stimulus and checks happen 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic push(input logic [IW-1:0] v);
    bit ok, rdy;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = v;
    for (int i = 0; i < 400; i++) begin
      rdy = s_ready;
      cyc();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_accept: sample %0d not accepted, got s_ready=0 expected 1", v);
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      cyc();
      k++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: got done=%0b expected 1 within 3000 cycles", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %0b expected 0", s_ready); end
    n_checks++;
    if ({input_Valid, m_valid, busy, done, timeout_err} !== 5'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b expected 00000", {input_Valid, m_valid, busy, done, timeout_err});
    end
    n_checks++;
    if (sample_count !== '0 || m_data !== '0 || FIR_input !== '0) begin
      n_fail++; $display("FAIL rst_data: got cnt=%0d m_data=%0d fir_in=%0d expected 0", sample_count, m_data, FIR_input);
    end
    reset = 1'b0;
    cyc();
    n_checks++;
    if (s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_release_ready: got %0b/%0b expected 1/1", s_ready, b_s_ready);
    end
  endtask

  task automatic test_basic();
    int s0, r0, p0;
    logic [OW-1:0] exp_r;
    m_ready = 1'b1;
    s0 = samp_q.size();
    r0 = res_q.size();
    p0 = pulse_cnt;
    for (int i = 1; i <= 4; i++) push(IW'(i));
    pulse_start();
    wait_done("basic");
    repeat (3) cyc();
    n_checks++;
    if (res_q.size() - r0 != 4) begin n_fail++; $display("FAIL basic_nres: got %0d expected 4", res_q.size() - r0); end
    for (int i = 0; i < 4; i++) begin
      exp_r = OW'(3 * (i + 1));
      n_checks++;
      if (res_q.size() > r0 + i) begin
        if (res_q[r0 + i] !== exp_r) begin
          n_fail++; $display("FAIL basic_m_data[%0d]: got %0d expected %0d", i, res_q[r0 + i], exp_r);
        end
      end else begin
        n_fail++; $display("FAIL basic_m_data[%0d]: got none expected %0d", i, exp_r);
      end
      n_checks++;
      if (samp_q.size() <= s0 + i || samp_q[s0 + i] !== IW'(i + 1)) begin
        n_fail++; $display("FAIL hold_sample[%0d]: got %0d expected %0d", i,
                           (samp_q.size() > s0 + i) ? samp_q[s0 + i] : '1, i + 1);
      end
    end
    n_checks++;
    if (pulse_cnt - p0 != 4) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 4", pulse_cnt - p0); end
    n_checks++;
    if (sample_count !== CW'(4) || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_count: got cnt=%0d busy=%0b expected 4/0", sample_count, busy);
    end
    n_checks++;
    if (double_iv !== 1'b0) begin n_fail++; $display("FAIL basic_double_pulse: got 1 expected 0"); end
  endtask

  task automatic test_stray_and_starve();
    bit mv_seen;
    int p0;
    // stray strobe while DONE
    mv_seen = 1'b0;
    stray_cnt++;
    repeat (6) begin cyc(); if (m_valid) mv_seen = 1'b1; end
    n_checks++;
    if (mv_seen || done !== 1'b1) begin
      n_fail++; $display("FAIL stray_idle: got m_valid_seen=%0b done=%0b expected 0/1", mv_seen, done);
    end
    // start with an empty FIFO: the run must park in FETCH
    p0 = pulse_cnt;
    pulse_start();
    mv_seen = 1'b0;
    repeat (10) cyc();
    stray_cnt++;
    repeat (20) begin cyc(); if (m_valid) mv_seen = 1'b1; end
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sample_count !== '0) begin
      n_fail++; $display("FAIL starve_state: got busy=%0b done=%0b cnt=%0d expected 1/0/0", busy, done, sample_count);
    end
    n_checks++;
    if (pulse_cnt != p0) begin n_fail++; $display("FAIL starve_pulses: got %0d expected 0", pulse_cnt - p0); end
    n_checks++;
    if (mv_seen) begin n_fail++; $display("FAIL stray_fetch: got m_valid=1 expected 0"); end
  endtask

  // Continues the starved run: the first push is consumed at once, the next four fill the FIFO.
  task automatic test_back_pressure();
    int r0, p0, k;
    bit unstable;
    logic [OW-1:0] d0;
    m_ready = 1'b0;
    r0 = res_q.size();
    for (int i = 10; i <= 14; i++) push(IW'(i));
    k = 0;
    while (!m_valid && k < 1000) begin cyc(); k++; end
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got 0 expected 1"); end
    d0 = m_data;
    p0 = pulse_cnt;
    unstable = 1'b0;
    repeat (50) begin cyc(); if (m_data !== d0 || m_valid !== 1'b1) unstable = 1'b1; end
    n_checks++;
    if (unstable || d0 !== OW'(30)) begin
      n_fail++; $display("FAIL bp_hold: got m_data=%0d unstable=%0b expected 30 stable", d0, unstable);
    end
    n_checks++;
    if (pulse_cnt != p0 || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall: got pulses=%0d s_ready=%0b expected 0/0", pulse_cnt - p0, s_ready);
    end
    m_ready = 1'b1;
    wait_done("bp");
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (res_q.size() <= r0 + i || res_q[r0 + i] !== OW'(3 * (10 + i))) begin
        n_fail++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i,
                           (res_q.size() > r0 + i) ? res_q[r0 + i] : '1, 3 * (10 + i));
      end
    end
    n_checks++;
    if (double_iv !== 1'b0) begin n_fail++; $display("FAIL bp_double_pulse: got 1 expected 0"); end
  endtask

  task automatic test_timeout();
    bit seen;
    int k;
    n_checks++;
    if (b_s_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got 0 expected 1"); end
    b_s_data  = IW'(7);
    b_s_valid = 1'b1;
    cyc();
    b_s_valid = 1'b0;
    b_start   = 1'b1;
    cyc();
    b_start   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (b_iv) begin seen = 1'b1; break; end
      cyc();
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL to_issue: got no input_Valid expected one"); end
    k = 0;
    while (!b_to && k < 100) begin cyc(); k++; end
    n_checks++;
    if (k != 16) begin n_fail++; $display("FAIL to_latency: got %0d cycles expected 16", k); end
    n_checks++;
    if (b_to !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0) begin
      n_fail++; $display("FAIL to_flags: got err=%0b busy=%0b done=%0b expected 1/0/0", b_to, b_busy, b_done);
    end
    repeat (5) cyc();
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    n_checks++;
    if (b_to !== 1'b0 || b_busy !== 1'b1) begin
      n_fail++; $display("FAIL to_restart: got err=%0b busy=%0b expected 0/1", b_to, b_busy);
    end
  endtask

  // Sample 14 is still queued from the back-pressure run; it is issued then aborted.
  task automatic test_reset_mid_wait();
    bit seen;
    int p0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (input_Valid) begin seen = 1'b1; break; end
      cyc();
    end
    repeat (5) cyc();
    n_checks++;
    if (!seen || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_issue: got seen=%0b busy=%0b expected 1/1", seen, busy);
    end
    reset = 1'b1;
    cyc();
    n_checks++;
    if ({input_Valid, m_valid, busy, done, timeout_err, s_ready} !== 6'b0) begin
      n_fail++; $display("FAIL mid_rst_flags: got %b expected 000000",
                         {input_Valid, m_valid, busy, done, timeout_err, s_ready});
    end
    n_checks++;
    if (FIR_input !== '0 || m_data !== '0 || sample_count !== '0) begin
      n_fail++; $display("FAIL mid_rst_data: got fir_in=%0d m_data=%0d cnt=%0d expected 0", FIR_input, m_data, sample_count);
    end
    reset = 1'b0;
    cyc();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got 0 expected 1"); end
    p0 = pulse_cnt;
    repeat (20) cyc();
    n_checks++;
    if (pulse_cnt != p0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_idle: got pulses=%0d busy=%0b expected 0/0", pulse_cnt - p0, busy);
    end
    pulse_start();
    repeat (30) cyc();
    n_checks++;
    if (pulse_cnt != p0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_fifo_empty: got pulses=%0d busy=%0b expected 0/1", pulse_cnt - p0, busy);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b1;
    b_start   = 1'b0;
    b_s_valid = 1'b0;
    b_s_data  = '0;
    output_Valid = 1'b0;
    FIR_output   = '0;
    test_reset();
    test_basic();
    test_stray_and_starve();
    test_back_pressure();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
